// File: rtl/tm_pkt_tx_buf_pkg.sv
`default_nettype none
//==============================================================================
// Module : tm_pkt_tx_buf_pkg
// Purpose: Shared timing-model packet definitions (libtm slice): clock and
//          token types, the fixed 128-bit packet layout, and pack/unpack
//          helpers used by the TX capture buffer and the RX side.
// Ports  : none (package)
// Rev    : 1.0  initial release
//==============================================================================
package tm_pkt_tx_buf_pkg;

   localparam int NTHREADIDMSB = 1;
   localparam int TID_W        = NTHREADIDMSB + 1;

   // Packet geometry
   localparam int TM_PKT_W    = 128;
   localparam int NPC_LSB     = 0;
   localparam int PADDR_LSB   = 32;
   localparam int INST_LSB    = 64;
   localparam int RETIRED_BIT = 96;
   localparam int REPLAY_BIT  = 98;
   localparam int RUN_BIT     = 99;
   localparam int VALID_BIT   = 100;
   localparam int TID_LSB     = 101;
   localparam int SEQ_LSB     = 120;
   localparam int SEQ_W       = 8;

   typedef struct packed {
      logic clk;
   } iu_clk_type;

   typedef struct packed {
      logic                  valid;
      logic [NTHREADIDMSB:0] tid;
      logic [31:0]           npc;
      logic [31:0]           paddr;
      logic [31:0]           inst;
      logic                  retired;
      logic                  replay;
      logic                  run;
   } tm_cpu_ctrl_token_type;

   // Bit 97 and the gap between the tid field and the seq byte stay zero.
   function automatic logic [TM_PKT_W-1:0] tm_pkt_pack(
      input tm_cpu_ctrl_token_type tok,
      input logic [SEQ_W-1:0]      seq
   );
      logic [TM_PKT_W-1:0] p;
      p                     = '0;
      p[NPC_LSB   +: 32]    = tok.npc;
      p[PADDR_LSB +: 32]    = tok.paddr;
      p[INST_LSB  +: 32]    = tok.inst;
      p[RETIRED_BIT]        = tok.retired;
      p[REPLAY_BIT]         = tok.replay;
      p[RUN_BIT]            = tok.run;
      p[VALID_BIT]          = tok.valid;
      p[TID_LSB   +: TID_W] = tok.tid;
      p[SEQ_LSB   +: SEQ_W] = seq;
      return p;
   endfunction

   function automatic tm_cpu_ctrl_token_type tm_pkt_unpack(
      input logic [TM_PKT_W-1:0] p
   );
      tm_cpu_ctrl_token_type tok;
      tok.npc     = p[NPC_LSB   +: 32];
      tok.paddr   = p[PADDR_LSB +: 32];
      tok.inst    = p[INST_LSB  +: 32];
      tok.retired = p[RETIRED_BIT];
      tok.replay  = p[REPLAY_BIT];
      tok.run     = p[RUN_BIT];
      tok.valid   = p[VALID_BIT];
      tok.tid     = p[TID_LSB   +: TID_W];
      return tok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tm_pkt_tx_buf_fifo_ram.sv
`default_nettype none
//==============================================================================
// Module : tm_pkt_fifo_ram
// Purpose: DEPTH x W distributed-RAM packet store. One synchronous write port,
//          one asynchronous read port. The array carries no reset.
// Ports  : gclk  - clock (posedge gclk.clk)
//          we    - write enable
//          waddr - write address
//          wdata - write data
//          raddr - read address
//          rdata - read data (combinational)
// Rev    : 1.0  initial release
//==============================================================================
module tm_pkt_fifo_ram
   import tm_pkt_tx_buf_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int W     = 128,
   parameter int AW    = $clog2(DEPTH)
) (
   input  iu_clk_type      gclk,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [W-1:0]    wdata,
   input  logic [AW-1:0]   raddr,
   output logic [W-1:0]    rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge gclk.clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/tm_pkt_tx_buf.sv
`default_nettype none
//==============================================================================
// Module : tm_pkt_tx_buf
// Purpose: Captures CPU timing-model tokens, packs them into 128-bit packets,
//          buffers them and presents them to the Ethernet TX path through a
//          registered first-word-fall-through valid/ready output. Overflowing
//          packets are dropped and counted.
// Config : TM_PKT_SEQ_EN - when defined, an 8-bit sequence number is kept and
//          carried in packet bits [127:120]; otherwise those bits are zero.
// Ports  : gclk      - clock (posedge gclk.clk)
//          rst       - synchronous active-high reset
//          enable    - capture enable (draining continues when low)
//          flush     - synchronous buffer clear, counters kept
//          tok_in    - token from the CPU, captured when tok_in.valid
//          pkt_out   - packet presented to TX
//          pkt_valid - pkt_out holds a packet
//          pkt_ready - TX accepts pkt_out this cycle
//          level     - packets held, output register included
//          overflow  - sticky drop indicator
//          drop_cnt  - saturating dropped-packet count
// Rev    : 1.0  initial release
//==============================================================================
module tm_pkt_tx_buf
   import tm_pkt_tx_buf_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DROP_W = 16
) (
   input  iu_clk_type                 gclk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       flush,
   input  tm_cpu_ctrl_token_type      tok_in,
   output logic [TM_PKT_W-1:0]        pkt_out,
   output logic                       pkt_valid,
   input  logic                       pkt_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [DROP_W-1:0]          drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [SEQ_W-1:0]    seq;
   logic [TM_PKT_W-1:0] pkt_in;
   logic [TM_PKT_W-1:0] ram_rdata;
   logic [LW-1:0]       ram_cnt;
   logic                ram_nonempty;
   logic                push_req;
   logic                pop;
   logic                accept;
   logic                drop;
   logic                out_load;
   logic                bypass;
   logic                ram_we;

   // Anything in flight during a flush cycle is discarded, so flush masks
   // both sides of the handshake here rather than in each consumer.
   assign push_req = enable & tok_in.valid & ~flush;
   assign pop      = pkt_valid & pkt_ready & ~flush;

   // A full buffer can still take a packet when the output drains this cycle.
   assign accept   = push_req & ((level != LVL_FULL) | pop);
   assign drop     = push_req & ~accept;

   // Entries behind the output register.
   assign ram_cnt      = level - LW'(pkt_valid);
   assign ram_nonempty = (ram_cnt != '0);

   // The output register refills whenever it is empty or being consumed.
   // With nothing queued behind it, a new packet skips the RAM entirely.
   assign out_load = ~pkt_valid | pop;
   assign bypass   = out_load & ~ram_nonempty & accept;
   assign ram_we   = accept & ~bypass;

   assign pkt_in   = tm_pkt_pack(tok_in, seq);

   tm_pkt_fifo_ram #(
      .DEPTH (DEPTH),
      .W     (TM_PKT_W),
      .AW    (AW)
   ) u_ram (
      .gclk  (gclk),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata (pkt_in),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge gclk.clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         pkt_out   <= '0;
         pkt_valid <= 1'b0;
         overflow  <= 1'b0;
         drop_cnt  <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         pkt_out   <= '0;
         pkt_valid <= 1'b0;
      end else begin
         level <= level + LW'(accept) - LW'(pop);

         if (ram_we) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end

         if (out_load) begin
            if (ram_nonempty) begin
               pkt_out   <= ram_rdata;
               pkt_valid <= 1'b1;
               rd_ptr    <= rd_ptr + PTR_ONE;
            end else if (accept) begin
               pkt_out   <= pkt_in;
               pkt_valid <= 1'b1;
            end else begin
               pkt_valid <= 1'b0;
            end
         end

         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + DROP_W'(1);
            end
         end
      end
   end

`ifdef TM_PKT_SEQ_EN
   // Advances only on accepted packets so the host sees a gap exactly when
   // buffered data was lost downstream, never for capture-side drops.
   always_ff @(posedge gclk.clk) begin
      if (rst) begin
         seq <= '0;
      end else if (accept) begin
         seq <= seq + SEQ_W'(1);
      end
   end
`else
   assign seq = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tm_pkt_tx_buf.sv
`default_nettype none
//==============================================================================
// Module : tb_tm_pkt_tx_buf
// Purpose: Self-checking bench for tm_pkt_tx_buf using a packet scoreboard.
//          Honours TM_PKT_SEQ_EN in its reference model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_tm_pkt_tx_buf;
   import tm_pkt_tx_buf_pkg::*;

   localparam int DEPTH  = 16;
   localparam int DROP_W = 16;

   iu_clk_type            gclk;
   logic                  rst;
   logic                  enable;
   logic                  flush;
   tm_cpu_ctrl_token_type tok;
   logic [127:0]          pkt_out;
   logic                  pkt_valid;
   logic                  pkt_ready;
   logic [4:0]            level;
   logic                  overflow;
   logic [DROP_W-1:0]     drop_cnt;

   int total = 0;
   int bad   = 0;

   tm_pkt_tx_buf #(
      .DEPTH  (DEPTH),
      .DROP_W (DROP_W)
   ) dut (
      .gclk      (gclk),
      .rst       (rst),
      .enable    (enable),
      .flush     (flush),
      .tok_in    (tok),
      .pkt_out   (pkt_out),
      .pkt_valid (pkt_valid),
      .pkt_ready (pkt_ready),
      .level     (level),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   initial gclk.clk = 1'b0;
   always #5 gclk.clk = ~gclk.clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference packet layout written out field by field.
   function automatic logic [127:0] exp_pkt(input tm_cpu_ctrl_token_type t, input logic [7:0] s);
      logic [127:0] p;
      p           = '0;
      p[31:0]     = t.npc;
      p[63:32]    = t.paddr;
      p[95:64]    = t.inst;
      p[96]       = t.retired;
      p[98]       = t.replay;
      p[99]       = t.run;
      p[100]      = t.valid;
      p[102:101]  = t.tid;
      p[127:120]  = s;
      return p;
   endfunction

   function automatic tm_cpu_ctrl_token_type rand_tok();
      tm_cpu_ctrl_token_type t;
      t.valid   = 1'b1;
      t.tid     = 2'($urandom_range(0, 3));
      t.npc     = $urandom;
      t.paddr   = $urandom;
      t.inst    = $urandom;
      t.retired = 1'($urandom_range(0, 1));
      t.replay  = 1'($urandom_range(0, 1));
      t.run     = 1'($urandom_range(0, 1));
      return t;
   endfunction

   task automatic tick();
      @(posedge gclk.clk);
      #1;
   endtask

   // ---------------- scoreboard ----------------
   logic [127:0]      q[$];
   logic [127:0]      popped;
   logic [7:0]        m_seq;
   logic [DROP_W-1:0] m_drop;
   logic              m_ovf;
   logic              m_ok = 1'b0;

   always @(negedge gclk.clk) begin
      logic m_full;
      logic m_pop;
      if (rst) begin
         q.delete();
         m_seq  = '0;
         m_drop = '0;
         m_ovf  = 1'b0;
         m_ok   = 1'b1;
      end else if (m_ok) begin
         chk("level",    128'(level),     128'(q.size()));
         chk("valid",    128'(pkt_valid), 128'(q.size() != 0));
         chk("overflow", 128'(overflow),  128'(m_ovf));
         chk("drop_cnt", 128'(drop_cnt),  128'(m_drop));
         if (flush) begin
            q.delete();
         end else begin
            m_full = (q.size() == DEPTH);
            m_pop  = (q.size() != 0) && pkt_ready;
            if (m_pop) begin
               chk("pkt", pkt_out, q[0]);
`ifndef TM_PKT_SEQ_EN
               chk("seq_zero", 128'(pkt_out[127:120]), 128'(0));
`endif
               popped = q.pop_front();
            end
            if (enable && tok.valid) begin
               if (!m_full || m_pop) begin
                  q.push_back(exp_pkt(tok, m_seq));
`ifdef TM_PKT_SEQ_EN
                  m_seq = m_seq + 8'd1;
`endif
               end else begin
                  m_ovf = 1'b1;
                  if (m_drop != '1) m_drop = m_drop + 1'b1;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int gaps;
      rst       = 1'b1;
      enable    = 1'b1;
      flush     = 1'b0;
      pkt_ready = 1'b0;
      tok       = '0;
      repeat (3) tick();
      chk("rst_pkt_out",  pkt_out, 128'(0));
      chk("rst_valid",    128'(pkt_valid), 128'(0));
      chk("rst_level",    128'(level), 128'(0));
      chk("rst_overflow", 128'(overflow), 128'(0));
      chk("rst_drop",     128'(drop_cnt), 128'(0));
      rst = 1'b0;
      tick();

      // 1: single token, one-cycle latency
      tok         = '0;
      tok.valid   = 1'b1;
      tok.npc     = 32'h1000;
      tok.inst    = 32'h8210_0001;
      tok.tid     = 2'd1;
      pkt_ready   = 1'b1;
      tick();
      tok = '0;
      chk("t1_valid", 128'(pkt_valid), 128'(1));
      chk("t1_npc",   128'(pkt_out[31:0]), 128'(32'h1000));
      chk("t1_inst",  128'(pkt_out[95:64]), 128'(32'h8210_0001));
      chk("t1_vbit",  128'(pkt_out[100]), 128'(1));
      chk("t1_seq",   128'(pkt_out[127:120]), 128'(0));
      tick();
      chk("t1_level", 128'(level), 128'(0));

      // 2: overflow with output stalled, then drain
      pkt_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tok = rand_tok();
         tick();
      end
      tok = '0;
      chk("t2_level", 128'(level), 128'(16));
      chk("t2_drop",  128'(drop_cnt), 128'(4));
      chk("t2_ovf",   128'(overflow), 128'(1));
      pkt_ready = 1'b1;
      repeat (20) tick();
      chk("t2_drained", 128'(level), 128'(0));

      // 3: push into a full buffer while it drains
      pkt_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tok = rand_tok();
         tick();
      end
      chk("t3_full", 128'(level), 128'(16));
      tok       = rand_tok();
      pkt_ready = 1'b1;
      tick();
      tok = '0;
      chk("t3_level", 128'(level), 128'(16));
      chk("t3_drop",  128'(drop_cnt), 128'(4));
      repeat (20) tick();
      chk("t3_drained", 128'(level), 128'(0));

      // 4: streaming, output must never bubble
      gaps      = 0;
      pkt_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tok = rand_tok();
         tick();
         if (!pkt_valid) gaps++;
      end
      tok = '0;
      chk("t4_gaps", 128'(gaps), 128'(0));
      chk("t4_drop", 128'(drop_cnt), 128'(4));
      repeat (3) tick();

      // 5: flush with data buffered and a push/pop in the flush cycle
      pkt_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tok = rand_tok();
         tick();
      end
      chk("t5_level", 128'(level), 128'(5));
      chk("t5_valid", 128'(pkt_valid), 128'(1));
      flush     = 1'b1;
      tok       = rand_tok();
      pkt_ready = 1'b1;
      tick();
      flush = 1'b0;
      tok   = '0;
      chk("t5_flush_level", 128'(level), 128'(0));
      chk("t5_flush_valid", 128'(pkt_valid), 128'(0));
      chk("t5_flush_ovf",   128'(overflow), 128'(1));
      chk("t5_flush_drop",  128'(drop_cnt), 128'(4));
      tok = rand_tok();
      tick();
      tok = '0;
      repeat (2) tick();

      // 6: capture disabled
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tok = rand_tok();
         tick();
      end
      chk("t6_level", 128'(level), 128'(0));
      chk("t6_drop",  128'(drop_cnt), 128'(4));
      enable = 1'b1;
      tok    = '0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
